// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofs_fim_pcie_ss_shims_pkg
// Purpose  : Shared types and widths for the PCIe SS RX segment realigner.
// Revision : 1.0 - initial release
// ============================================================================
package ofs_fim_pcie_ss_shims_pkg;

    localparam int SEG_WIDTH  = 256;
    localparam int HDR_WIDTH  = 256;
    localparam int SEG_KEEP_W = SEG_WIDTH / 8;

    // Per-segment side-band user field, MSB to LSB.
    typedef struct packed {
        logic                 vendor;
        logic                 last_segment;
        logic                 hvalid;
        logic [HDR_WIDTH-1:0] hdr;
    } t_tuser_seg;

    // One buffered segment: user field, keep and payload travel together.
    typedef struct packed {
        t_tuser_seg            user;
        logic [SEG_KEEP_W-1:0] keep;
        logic [SEG_WIDTH-1:0]  data;
    } t_seg_entry;

    // Segment buffer depth for a given input segment count.
    function automatic int seg_buf_depth(input int num_seg);
        return 2 * num_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_ss_rx_seg_align_if.sv
`default_nettype none
// ============================================================================
// Module   : pcie_ss_rx_seg_align_if
// Purpose  : Segmented AXI-S bundle (valid/ready/data/keep/last/user).
//            USER_SEGS sets how many t_tuser_seg fields ride on the bus.
// Revision : 1.0 - initial release
// ============================================================================
interface pcie_ss_rx_seg_align_if
    import ofs_fim_pcie_ss_shims_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int USER_SEGS  = 2
);
    logic                          tvalid;
    logic                          tready;
    logic [DATA_WIDTH-1:0]         tdata;
    logic [DATA_WIDTH/8-1:0]       tkeep;
    logic                          tlast;
    t_tuser_seg [USER_SEGS-1:0]    tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input  tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/pcie_ss_rx_seg_align_seg_buf.sv
`default_nettype none
// ============================================================================
// Module   : pcie_ss_rx_seg_buf
// Purpose  : Multi-push / multi-pop segment FIFO. Pops shift the contents
//            down, then flagged input segments are appended compacted.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_ss_rx_seg_buf
    import ofs_fim_pcie_ss_shims_pkg::*;
#(
    parameter  int NUM_OF_SEG = 2,
    localparam int DEPTH      = seg_buf_depth(NUM_OF_SEG),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic       [NUM_OF_SEG-1:0] push_vld_i,
    input  t_seg_entry [NUM_OF_SEG-1:0] push_seg_i,
    input  logic       [CNT_W-1:0]      pop_cnt_i,
    output t_seg_entry [NUM_OF_SEG-1:0] head_o,
    output logic       [CNT_W-1:0]      count_o
);
    localparam int IDX_W = $clog2(DEPTH);

    t_seg_entry       mem_q [DEPTH];
    t_seg_entry       mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Shift out popped entries, then append accepted segments in order.
    always_comb begin
        int src;
        int wr;
        src     = 0;
        wr      = 0;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            src = i + int'(pop_cnt_i);
            if (src < int'(count_q)) mem_d[i] = mem_q[src[IDX_W-1:0]];
            else                     mem_d[i] = '0;
        end
        wr = int'(count_q) - int'(pop_cnt_i);
        for (int j = 0; j < NUM_OF_SEG; j++) begin
            if (push_vld_i[j]) begin
                if (wr < DEPTH) mem_d[wr[IDX_W-1:0]] = push_seg_i[j];
                wr = wr + 1;
            end
        end
        count_d = wr[CNT_W-1:0];
    end

    // Storage and occupancy; only the count needs a reset value.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    generate
        for (genvar k = 0; k < NUM_OF_SEG; k++) begin : g_head
            assign head_o[k] = mem_q[k];
        end
    endgenerate

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pcie_ss_rx_seg_align.sv
`default_nettype none
// ============================================================================
// Module   : pcie_ss_rx_seg_align
// Purpose  : Realigns a segmented RX stream so each packet starts in segment
//            0 and each output beat carries at most one packet.
// Options  : PCIE_SS_RX_SEG_ALIGN_ASSERT_EN - compiles in protocol checks.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_ss_rx_seg_align
    import ofs_fim_pcie_ss_shims_pkg::*;
#(
    parameter  int DATA_WIDTH = 512,
    parameter  int NUM_OF_SEG = 2,
    localparam int SEG_W      = DATA_WIDTH / NUM_OF_SEG
) (
    input  logic                    clk,
    input  logic                    rst,
    pcie_ss_rx_seg_align_if.slave   in_i,
    pcie_ss_rx_seg_align_if.master  out_o
);
    localparam int DEPTH = seg_buf_depth(NUM_OF_SEG);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                        open_q, open_d;
    logic [NUM_OF_SEG-1:0]       w_seg_vld;
    t_seg_entry [NUM_OF_SEG-1:0] w_push_seg;
    t_seg_entry [NUM_OF_SEG-1:0] w_head;
    logic [CNT_W-1:0]            w_count;
    logic [CNT_W-1:0]            w_emit_cnt;
    logic [CNT_W-1:0]            w_pop_cnt;
    logic                        w_emit_last;
    logic                        w_load;
    logic                        w_in_ready;
    logic                        w_in_fire;

    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q,  out_last_d;
    logic [DATA_WIDTH-1:0]       out_data_q,  out_data_d;
    logic [DATA_WIDTH/8-1:0]     out_keep_q,  out_keep_d;
    t_tuser_seg                  out_user_q,  out_user_d;

    // Classify input segments in bus order; packet state walks across them.
    always_comb begin
        logic open_v;
        open_v     = open_q;
        open_d     = open_q;
        w_seg_vld  = '0;
        w_push_seg = '0;
        for (int i = 0; i < NUM_OF_SEG; i++) begin
            w_push_seg[i].data = in_i.tdata[i*SEG_W +: SEG_W];
            w_push_seg[i].keep = in_i.tkeep[i*(SEG_W/8) +: (SEG_W/8)];
            w_push_seg[i].user = in_i.tuser[i];
            w_seg_vld[i] = in_i.tuser[i].hvalid | (open_v & (|w_push_seg[i].keep));
            if (in_i.tuser[i].hvalid)                     open_v = 1'b1;
            if (w_seg_vld[i] && in_i.tuser[i].last_segment) open_v = 1'b0;
        end
        if (w_in_fire) open_d = open_v;
    end

    pcie_ss_rx_seg_buf #(.NUM_OF_SEG(NUM_OF_SEG)) u_seg_buf (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (w_seg_vld & {NUM_OF_SEG{w_in_fire}}),
        .push_seg_i (w_push_seg),
        .pop_cnt_i  (w_pop_cnt),
        .head_o     (w_head),
        .count_o    (w_count)
    );

    // Beat size: up to and including the first closing segment, else a full beat.
    always_comb begin
        logic found;
        found       = 1'b0;
        w_emit_cnt  = '0;
        w_emit_last = 1'b0;
        for (int k = 0; k < NUM_OF_SEG; k++) begin
            if (!found && (k < int'(w_count)) && w_head[k].user.last_segment) begin
                found       = 1'b1;
                w_emit_cnt  = CNT_W'(k + 1);
                w_emit_last = 1'b1;
            end
        end
        if (!found && (w_count >= CNT_W'(NUM_OF_SEG))) w_emit_cnt = CNT_W'(NUM_OF_SEG);
    end

    assign w_load     = !out_valid_q || out_o.tready;
    assign w_pop_cnt  = w_load ? w_emit_cnt : '0;
    // Ready looks ahead past this cycle's pop so a full beat can always land.
    assign w_in_ready = !rst &&
                        ((int'(w_count) - int'(w_pop_cnt) + NUM_OF_SEG) <= DEPTH);
    assign w_in_fire  = in_i.tvalid && w_in_ready;

    // Next output beat: oldest segments packed from segment 0, rest zeroed.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_user_d  = out_user_q;
        if (w_load) begin
            out_valid_d = (w_emit_cnt != '0);
            out_last_d  = w_emit_last;
            out_data_d  = '0;
            out_keep_d  = '0;
            for (int k = 0; k < NUM_OF_SEG; k++) begin
                if (k < int'(w_emit_cnt)) begin
                    out_data_d[k*SEG_W +: SEG_W]         = w_head[k].data;
                    out_keep_d[k*(SEG_W/8) +: (SEG_W/8)] = w_head[k].keep;
                end
            end
            // Only an opening segment carries hvalid, so it marks a first beat.
            out_user_d              = '0;
            out_user_d.last_segment = w_emit_last;
            if ((w_emit_cnt != '0) && w_head[0].user.hvalid) begin
                out_user_d.hvalid = 1'b1;
                out_user_d.hdr    = w_head[0].user.hdr;
                out_user_d.vendor = w_head[0].user.vendor;
            end
        end
    end

    // Packet-open flag and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            open_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
        end else begin
            open_q      <= open_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_user_q  <= out_user_d;
        end
    end

    assign in_i.tready    = w_in_ready;
    assign out_o.tvalid   = out_valid_q;
    assign out_o.tlast    = out_last_q;
    assign out_o.tdata    = out_data_q;
    assign out_o.tkeep    = out_keep_q;
    assign out_o.tuser[0] = out_user_q;

`ifdef PCIE_SS_RX_SEG_ALIGN_ASSERT_EN
    logic a_hv_err;
    logic a_keep_err;

    // Walk the beat the same way as the classifier to spot protocol breaks.
    always_comb begin
        logic a_open;
        a_open     = open_q;
        a_hv_err   = 1'b0;
        a_keep_err = 1'b0;
        for (int i = 0; i < NUM_OF_SEG; i++) begin
            if (in_i.tuser[i].hvalid && a_open) a_hv_err = 1'b1;
            if (!in_i.tuser[i].hvalid && !a_open &&
                (|in_i.tkeep[i*(SEG_W/8) +: (SEG_W/8)])) a_keep_err = 1'b1;
            if (in_i.tuser[i].hvalid)                        a_open = 1'b1;
            if (w_seg_vld[i] && in_i.tuser[i].last_segment)  a_open = 1'b0;
        end
    end

    // Report violations on accepted beats and a bad width configuration.
    always_ff @(posedge clk) begin
        if (DATA_WIDTH != NUM_OF_SEG * SEG_WIDTH)
            $error("pcie_ss_rx_seg_align: DATA_WIDTH must be NUM_OF_SEG*256");
        if (!rst && w_in_fire) begin
            if (a_hv_err)   $error("pcie_ss_rx_seg_align: hvalid inside open packet");
            if (a_keep_err) $error("pcie_ss_rx_seg_align: keep outside a packet");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_ss_rx_seg_align.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pcie_ss_rx_seg_align
// Purpose  : Scoreboard bench for the RX segment realigner (512b, 2 segments).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_ss_rx_seg_align;
    import ofs_fim_pcie_ss_shims_pkg::*;

    localparam int DW = 512;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcie_ss_rx_seg_align_if #(.DATA_WIDTH(DW), .USER_SEGS(NS)) in_if ();
    pcie_ss_rx_seg_align_if #(.DATA_WIDTH(DW), .USER_SEGS(1))  out_if ();

    pcie_ss_rx_seg_align #(.DATA_WIDTH(DW), .NUM_OF_SEG(NS)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .in_i  (in_if.slave),
        .out_o (out_if.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         hv;
        logic         vendor;
        logic [255:0] hdr;
    } exp_t;

    exp_t         sb_q[$];
    logic         m_open;
    logic         m_first;
    logic         m_vendor;
    logic [255:0] m_hdr;
    int           m_n;
    logic [255:0] m_data [NS];
    logic [31:0]  m_keep [NS];

    function automatic void model_reset();
        m_open = 1'b0; m_first = 1'b0; m_n = 0;
    endfunction

    function automatic void model_emit(input logic last);
        exp_t e;
        e.data = '0; e.keep = '0;
        for (int i = 0; i < m_n; i++) begin
            e.data[i*256 +: 256] = m_data[i];
            e.keep[i*32 +: 32]   = m_keep[i];
        end
        e.last   = last;
        e.hv     = m_first;
        e.hdr    = m_first ? m_hdr : 256'd0;
        e.vendor = m_first ? m_vendor : 1'b0;
        m_first  = 1'b0;
        m_n      = 0;
        sb_q.push_back(e);
    endfunction

    function automatic void model_seg(input logic [255:0] d, input logic [31:0] k, input t_tuser_seg u);
        if (!(u.hvalid || (m_open && k != 32'd0))) return;
        if (u.hvalid) begin
            m_open = 1'b1; m_first = 1'b1; m_hdr = u.hdr; m_vendor = u.vendor;
        end
        m_data[m_n] = d; m_keep[m_n] = k; m_n++;
        if (u.last_segment) begin
            m_open = 1'b0;
            model_emit(1'b1);
        end else if (m_n == NS) begin
            model_emit(1'b0);
        end
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- output back-pressure ----------------
    int bp_mode = 0;   // 0: always ready, 1: low 1 in 16, 2: held low
    initial begin
        out_if.tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0:       out_if.tready = 1'b1;
                1:       out_if.tready = ($urandom_range(15) != 0);
                default: out_if.tready = 1'b0;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_tvalid", out_if.tvalid, 1'b0);
        end else if (out_if.tvalid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 1'b1, 1'b0);
            end else begin
                mon_e = sb_q[0];
                check("tdata",   out_if.tdata,                  mon_e.data);
                check("tkeep",   out_if.tkeep,                  mon_e.keep);
                check("tlast",   out_if.tlast,                  mon_e.last);
                check("lastseg", out_if.tuser[0].last_segment,  mon_e.last);
                check("hvalid",  out_if.tuser[0].hvalid,        mon_e.hv);
                check("hdr",     out_if.tuser[0].hdr,           mon_e.hdr);
                check("vendor",  out_if.tuser[0].vendor,        mon_e.vendor);
                if (out_if.tready) void'(sb_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input t_tuser_seg [NS-1:0] u);
        logic acc;
        int   budget;
        acc    = 1'b0;
        budget = 500;
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tuser  = u;
        in_if.tlast  = u[NS-1].last_segment;
        while (!acc && budget > 0) begin
            @(negedge clk);
            if (in_if.tready) begin
                acc = 1'b1;
                for (int i = 0; i < NS; i++) model_seg(d[i*256 +: 256], k[i*32 +: 32], u[i]);
            end
            budget--;
            @(posedge clk); #1;
        end
        if (!acc) check("in_accept_timeout", 1'b0, 1'b1);
        in_if.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (sb_q.size() != 0 && b > 0) begin @(posedge clk); #1; b--; end
        idle(2);
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic run_random(input int npkt, input logic ib);
        int           started;
        logic         g_open;
        int           g_rem;
        int           len;
        logic [511:0] d;
        logic [63:0]  k;
        t_tuser_seg [NS-1:0] u;
        started = 0; g_open = 1'b0; g_rem = 0;
        while (started < npkt || g_open) begin
            for (int s = 0; s < NS; s++) begin
                d[s*256 +: 256]   = rnd256();
                k[s*32 +: 32]     = 32'd0;
                u[s].hdr          = rnd256();
                u[s].vendor       = 1'($urandom);
                u[s].hvalid       = 1'b0;
                u[s].last_segment = 1'b0;
                if (g_open) begin
                    if ($urandom_range(7) != 0) begin
                        g_rem--;
                        if (g_rem == 0) begin
                            k[s*32 +: 32]     = 32'hFFFF_FFFF >> $urandom_range(31);
                            u[s].last_segment = 1'b1;
                            g_open            = 1'b0;
                        end else begin
                            k[s*32 +: 32] = 32'hFFFF_FFFF;
                        end
                    end
                end else if (started < npkt && $urandom_range(3) != 0) begin
                    len         = $urandom_range(1, 5);
                    started++;
                    u[s].hvalid = 1'b1;
                    if (ib) u[s].hdr = 256'd0;
                    if (len == 1) begin
                        k[s*32 +: 32]     = 32'hFFFF_FFFF >> $urandom_range(31);
                        u[s].last_segment = 1'b1;
                    end else begin
                        k[s*32 +: 32] = 32'hFFFF_FFFF;
                        g_open        = 1'b1;
                        g_rem         = len - 1;
                    end
                end
            end
            if ($urandom_range(7) == 0) idle(1);
            drive_beat(d, k, u);
        end
    endtask

    // ---------------- main sequence ----------------
    logic [511:0]        d;
    logic [63:0]         k;
    t_tuser_seg [NS-1:0] u;

    initial begin
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tkeep  = '0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_tready", in_if.tready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_tready", in_if.tready, 1'b1);
        check("post_rst_out_tvalid", out_if.tvalid, 1'b0);
        @(posedge clk); #1;

        // Packet starting in segment 1
        u = '0;
        u[0].hdr = {8{32'hDEAD_0000}};
        u[1].hvalid = 1'b1; u[1].last_segment = 1'b1; u[1].vendor = 1'b1;
        u[1].hdr = {8{32'h1111_2222}};
        d = {{8{32'hA1A1_0001}}, {8{32'h5A5A_0000}}};
        k = {32'hFFFF_FFFF, 32'h0};
        drive_beat(d, k, u);
        drain(50);

        // Two single-segment packets in one beat
        u = '0;
        u[0].hvalid = 1'b1; u[0].last_segment = 1'b1; u[0].hdr = {8{32'h0000_00A0}};
        u[1].hvalid = 1'b1; u[1].last_segment = 1'b1; u[1].hdr = {8{32'h0000_00B1}};
        d = {{8{32'hB1B1_B1B1}}, {8{32'hA0A0_A0A0}}};
        k = {32'hFFFF_FFFF, 32'h0000_00FF};
        drive_beat(d, k, u);
        drain(50);

        // Three-segment packet starting in segment 1, over two beats
        u = '0;
        u[1].hvalid = 1'b1; u[1].hdr = {8{32'h3333_0001}};
        d = {{8{32'hC001_C001}}, {8{32'hFFFF_0000}}};
        k = {32'hFFFF_FFFF, 32'h0};
        drive_beat(d, k, u);
        u = '0;
        u[0].hdr = {8{32'hBAD0_BAD0}}; u[0].vendor = 1'b1;
        u[1].last_segment = 1'b1;
        d = {{8{32'hC003_C003}}, {8{32'hC002_C002}}};
        k = {32'h0000_FFFF, 32'hFFFF_FFFF};
        drive_beat(d, k, u);
        drain(50);

        // Long back-pressure with a pending beat and more data queued behind it
        bp_mode = 2;
        idle(1);
        u = '0;
        u[0].hvalid = 1'b1; u[0].last_segment = 1'b1; u[0].hdr = {8{32'h5555_0000}};
        d = {{8{32'h0}}, {8{32'hD00D_0001}}};
        k = {32'h0, 32'hFFFF_FFFF};
        drive_beat(d, k, u);
        u = '0;
        u[0].hvalid = 1'b1; u[0].hdr = {8{32'h6666_0000}};
        d = {{8{32'hE00E_0002}}, {8{32'hE00E_0001}}};
        k = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        drive_beat(d, k, u);
        u = '0;
        u[0].last_segment = 1'b1;
        d = {{8{32'h0}}, {8{32'hE00E_0003}}};
        k = {32'h0, 32'h0000_0FFF};
        drive_beat(d, k, u);
        repeat (20) begin
            @(negedge clk);
            check("stall_tvalid", out_if.tvalid, 1'b1);
        end
        @(posedge clk); #1;
        bp_mode = 0;
        drain(50);

        // Reset in the middle of an open packet
        u = '0;
        u[0].hvalid = 1'b1; u[0].hdr = {8{32'h7777_0000}};
        d = {{8{32'h0}}, {8{32'hF00F_0001}}};
        k = {32'h0, 32'hFFFF_FFFF};
        drive_beat(d, k, u);
        idle(1);
        rst = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("midrst_in_tready", in_if.tready, 1'b0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        u = '0;
        u[1].hvalid = 1'b1; u[1].last_segment = 1'b1; u[1].hdr = {8{32'h8888_0000}};
        d = {{8{32'h1234_5678}}, {8{32'h0}}};
        k = {32'hFFFF_0000, 32'h0};
        drive_beat(d, k, u);
        drain(50);

        // Random traffic, side-band then in-band headers
        bp_mode = 1;
        run_random(5000, 1'b0);
        drain(2000);
        run_random(5000, 1'b1);
        drain(2000);
        bp_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
